bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-requester arbiter and sequencer for the SoC's single-port 32-bit block RAM. Sits between the picoRV32 core's native memory port (requester 0) and a second bus master such as a UART boot loader or DMA engine (requester 1). It owns the RAM's address, data and byte-write pins, issues one access at a time, and returns read data with a per-requester ready pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: RAM word-address width; the RAM holds 2**`ADDR_WIDTH` words, so the byte-address range is 4*2**`ADDR_WIDTH`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `m0_valid`, `m1_valid`  in  1  request pending.
- `m0_addr`, `m1_addr`  in  32  byte address; bits [1:0] ignored.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write enables; 0 means read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while the matching ready is high; 0 otherwise.
- `ram_addr`  out  `ADDR_WIDTH`  RAM word address.
- `ram_din`  out  32  RAM write data.
- `ram_we`  out  4  RAM byte write enables.
- `ram_dout`  in  32  RAM read data; one-cycle latency.
- `oor_err`  out  1  one-cycle pulse for an out-of-range access.
- `grant_id`  out  1  requester that owns the current or last access.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any eligible `mN_valid` is high, pick a winner and latch its addr, wdata, wstrb and id. Then go to ACCESS.
- ACCESS:
  - `ram_addr` is driven from latched addr[`ADDR_WIDTH`+1:2].
  - `ram_din` is driven from the latched wdata.
  - `ram_we` equals the latched wstrb, or 0 if out of range.
  - Always go to RESP.
- RESP:
  - Pulse the winner's `mN_ready` and drive `mN_rdata` from `ram_dout`. A write returns `ram_dout` unchanged; an out-of-range access returns 0.
  - Arbitrate again with the just-served requester excluded this cycle. If the other requester is waiting, go to ACCESS; otherwise go to IDLE.
- Out of range means latched addr[31:`ADDR_WIDTH`+2] != 0. Such an access still completes with ready, but the write is suppressed and `oor_err` pulses in RESP.
- Requester rule: hold valid and payload stable until ready. Valid may stay high in the cycle after ready to start the next request.
- Arbitration policy: see Configuration. When only one requester is eligible, it always wins.

## Timing
- Latency: `valid` seen in IDLE at cycle N, RAM pins driven in N+1, `ready` and `rdata` in N+2.
- Back-to-back accesses from alternating requesters complete every 2 cycles.
- A single requester streaming alone completes once every 3 cycles (RESP, then IDLE, then ACCESS).
- `ram_we` is nonzero only in ACCESS and never while `reset` is high.
- Reset values:
  - state IDLE;
  - all `mN_ready` 0, all `mN_rdata` 0;
  - `ram_we` 0, `ram_addr` 0, `ram_din` 0;
  - `oor_err` 0, `grant_id` 0;
  - round-robin pointer prefers requester 0.
- Reset mid-operation: the in-flight access is abandoned and no ready is issued. A write coinciding with `reset` in ACCESS is suppressed.
- Simultaneous `m0_valid` and `m1_valid` in IDLE: the policy decides. The loser waits and is served directly after the winner's RESP.

## Configuration
- `BRAM_ARB_RR_EN` defined:
  - Round-robin arbitration: on a tie, grant the requester not granted last.
  - The pointer updates on every grant.
- `BRAM_ARB_RR_EN` undefined:
  - Fixed priority, requester 0 (CPU) always wins ties.
  - The RESP-exclusion rule still guarantees requester 1 a slot between consecutive CPU accesses.

## Structure
- Package `bram_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - requester id constants `ARB_M0`, `ARB_M1`;
  - a helper function for the out-of-range check.
- Sub-module `bram_arb_select`: combinational picker that takes the valids, the exclude mask and the RR pointer, and returns grant and id. It holds the only `BRAM_ARB_RR_EN`-dependent logic.

## Test plan
- Single read: m0 reads 0x0000_0010 after the RAM was preloaded with 0xDEAD_BEEF at word 4 → `ram_addr`=4 at N+1; `m0_ready`=1 and `m0_rdata`=0xDEAD_BEEF at N+2.
- Byte write: m1 writes 0x1122_3344 with wstrb 0b0010 to 0x20, then m0 reads 0x20 → only byte 1 changes to 0x33.
- Contention: both valid in the same IDLE cycle.
  - Fixed priority: m0 is acked at N+2 and m1 at N+4.
  - With `BRAM_ARB_RR_EN` and last grant m0: m1 is acked first.
- Out of range: m0 writes to 0x0004_0000 with `ADDR_WIDTH`=16 → `ram_we` stays 0, `m0_ready` pulses, `m0_rdata`=0, `oor_err` pulses once.
- Reset in ACCESS during an m1 write → `ram_we`=0 that cycle, no `m1_ready`, state IDLE next cycle, RAM contents unchanged.
- Streaming: both requesters hold valid for 10 accesses each → grants alternate, one ready every 2 cycles, no requester starved.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-requester block-RAM arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // True when the byte address lies beyond a RAM of 2**aw 32-bit words.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return hi != 32'd0;
  endfunction

endpackage

// File: rtl/bram_arb_if.sv
// One requester's native memory port (picoRV32-style valid/ready handshake).
interface bram_arb_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/bram_arb_select.sv
// Combinational winner picker. BRAM_ARB_RR_EN selects round-robin tie-break,
// otherwise requester 0 wins ties.
module bram_arb_select
  import bram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic [1:0] excl,
  input  logic       pref,
  output logic       grant,
  output logic       gid
);

  logic [1:0] elig;

  always_comb begin
    elig  = valid & ~excl;
    grant = |elig;
`ifdef BRAM_ARB_RR_EN
    gid = (&elig) ? pref : (elig[0] ? ARB_M0 : ARB_M1);
`else
    gid = elig[0] ? ARB_M0 : ARB_M1;
`endif
  end

`ifndef BRAM_ARB_RR_EN
  logic unused_pref;
  assign unused_pref = pref;
`endif

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester sequencer for a single-port 32-bit BRAM: IDLE -> ACCESS -> RESP.
// Optional round-robin arbitration via BRAM_ARB_RR_EN (see bram_arb_select).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bram_arb_if.slave             m0,
  bram_arb_if.slave             m1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_we,
  input  logic [31:0]           ram_dout,
  output logic                  oor_err,
  output logic                  grant_id
);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        id_q, id_d;
  logic        pref_q, pref_d;

  logic [1:0] req_valid, excl;
  logic       grant, gid, oor;

  assign req_valid = {m1.valid, m0.valid};
  // The requester just served sits out the RESP-cycle arbitration.
  assign excl = (state_q == RESP) ? ((id_q == ARB_M1) ? 2'b10 : 2'b01) : 2'b00;
  assign oor  = addr_oor(addr_q, ADDR_WIDTH);

  bram_arb_select u_sel (
    .valid (req_valid),
    .excl  (excl),
    .pref  (pref_q),
    .grant (grant),
    .gid   (gid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      id_q    <= ARB_M0;
      pref_q  <= ARB_M0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      id_q    <= id_d;
      pref_q  <= pref_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    id_d    = id_q;
    pref_d  = pref_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (grant) begin
          state_d = ACCESS;
          addr_d  = (gid == ARB_M1) ? m1.addr  : m0.addr;
          wdata_d = (gid == ARB_M1) ? m1.wdata : m0.wdata;
          wstrb_d = (gid == ARB_M1) ? m1.wstrb : m0.wstrb;
          id_d    = gid;
          pref_d  = ~gid;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so an abandoned access never writes or acks.
  always_comb begin
    ram_addr = addr_q[ADDR_WIDTH+1:2];
    ram_din  = wdata_q;
    ram_we   = '0;
    oor_err  = 1'b0;
    grant_id = id_q;
    m0.ready = 1'b0;
    m0.rdata = '0;
    m1.ready = 1'b0;
    m1.rdata = '0;
    if (!reset) begin
      if (state_q == ACCESS && !oor) ram_we = wstrb_q;
      if (state_q == RESP) begin
        oor_err = oor;
        if (id_q == ARB_M0) begin
          m0.ready = 1'b1;
          m0.rdata = oor ? 32'd0 : ram_dout;
        end else begin
          m1.ready = 1'b1;
          m1.rdata = oor ? 32'd0 : ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: cycle table plus contention, streaming and reset sequences.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_we;
  logic [31:0] ram_dout = 32'd0;
  logic        oor_err;
  logic        grant_id;

  int checks = 0;
  int failures = 0;

  bram_arb_if m0_if ();
  bram_arb_if m1_if ();

  bram_arbiter #(.ADDR_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0       (m0_if),
    .m1       (m1_if),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .oor_err  (oor_err),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM with byte enables and one-cycle read latency.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0, wd0;
    logic [3:0]  ws0;
    logic        v1;
    logic [31:0] a1, wd1;
    logic [3:0]  ws1;
    logic        r0;
    logic [31:0] rd0;
    logic        r1;
    logic [31:0] rd1;
    logic [3:0]  we;
    logic [15:0] ra;
    logic        oor;
    logic        gid;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, input logic [31:0] a0, input logic [31:0] wd0, input logic [3:0] ws0,
    input logic v1, input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] ws1,
    input logic r0, input logic [31:0] rd0, input logic r1, input logic [31:0] rd1,
    input logic [3:0] we, input logic [15:0] ra, input logic oor, input logic gid);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.wd0 = wd0; v.ws0 = ws0;
    v.v1 = v1; v.a1 = a1; v.wd1 = wd1; v.ws1 = ws1;
    v.r0 = r0; v.rd0 = rd0; v.r1 = r1; v.rd1 = rd1;
    v.we = we; v.ra = ra; v.oor = oor; v.gid = gid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] wd0, input logic [3:0] ws0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] ws1);
    m0_if.valid = v0; m0_if.addr = a0; m0_if.wdata = wd0; m0_if.wstrb = ws0;
    m1_if.valid = v1; m1_if.addr = a1; m1_if.wdata = wd1; m1_if.wstrb = ws1;
  endtask

  localparam int NV = 16;
  vec_t vt [NV];

  initial begin
    int t0, t1;
    logic [31:0] d0, d1;
    int n0, n1, nr, alt_err, gap_err, rd_err, last_c;
    logic last_id;

    for (int i = 0; i < 65536; i++) mem[i] <= 32'd0;
    mem[4]  <= 32'hDEAD_BEEF;
    mem[8]  <= 32'hAABB_CCDD;
    mem[12] <= 32'h0BAD_F00D;

    // m0 read, m1 byte write, m0 read-back, m0 out-of-range write
    vt[0]  = mk(0,0,0,0,                    0,0,0,0,                  0,0,0,0,                        0,16'd0,0,0);
    vt[1]  = mk(1,32'h10,0,0,               0,0,0,0,                  0,0,0,0,                        0,16'd0,0,0);
    vt[2]  = mk(1,32'h10,0,0,               0,0,0,0,                  0,0,0,0,                        0,16'd4,0,0);
    vt[3]  = mk(1,32'h10,0,0,               0,0,0,0,                  1,32'hDEAD_BEEF,0,0,            0,16'd4,0,0);
    vt[4]  = mk(0,0,0,0,                    0,0,0,0,                  0,0,0,0,                        0,16'd4,0,0);
    vt[5]  = mk(0,0,0,0,                    1,32'h20,32'h1122_3344,4'b0010, 0,0,0,0,                  0,16'd4,0,0);
    vt[6]  = mk(0,0,0,0,                    1,32'h20,32'h1122_3344,4'b0010, 0,0,0,0,                  4'b0010,16'd8,0,1);
    vt[7]  = mk(0,0,0,0,                    1,32'h20,32'h1122_3344,4'b0010, 0,0,1,32'hAABB_CCDD,      0,16'd8,0,1);
    vt[8]  = mk(1,32'h20,0,0,               0,0,0,0,                  0,0,0,0,                        0,16'd8,0,1);
    vt[9]  = mk(1,32'h20,0,0,               0,0,0,0,                  0,0,0,0,                        0,16'd8,0,0);
    vt[10] = mk(1,32'h20,0,0,               0,0,0,0,                  1,32'hAABB_33DD,0,0,            0,16'd8,0,0);
    vt[11] = mk(0,0,0,0,                    0,0,0,0,                  0,0,0,0,                        0,16'd8,0,0);
    vt[12] = mk(1,32'h0004_0000,32'hFFFF_FFFF,4'hF, 0,0,0,0,          0,0,0,0,                        0,16'd8,0,0);
    vt[13] = mk(1,32'h0004_0000,32'hFFFF_FFFF,4'hF, 0,0,0,0,          0,0,0,0,                        0,16'd0,0,0);
    vt[14] = mk(1,32'h0004_0000,32'hFFFF_FFFF,4'hF, 0,0,0,0,          1,32'd0,0,0,                    0,16'd0,1,0);
    vt[15] = mk(0,0,0,0,                    0,0,0,0,                  0,0,0,0,                        0,16'd0,0,0);

    // Reset, with a request already pending to prove nothing is served during it
    reset = 1'b1;
    drive(1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_m0_ready", {31'd0, m0_if.ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_if.ready}, 32'd0);
    chk("rst_m0_rdata", m0_if.rdata, 32'd0);
    chk("rst_m1_rdata", m1_if.rdata, 32'd0);
    chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    chk("rst_oor_err", {31'd0, oor_err}, 32'd0);
    chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].v0, vt[i].a0, vt[i].wd0, vt[i].ws0, vt[i].v1, vt[i].a1, vt[i].wd1, vt[i].ws1);
      #1;
      chk($sformatf("row%0d_m0_ready", i), {31'd0, m0_if.ready}, {31'd0, vt[i].r0});
      chk($sformatf("row%0d_m0_rdata", i), m0_if.rdata, vt[i].rd0);
      chk($sformatf("row%0d_m1_ready", i), {31'd0, m1_if.ready}, {31'd0, vt[i].r1});
      chk($sformatf("row%0d_m1_rdata", i), m1_if.rdata, vt[i].rd1);
      chk($sformatf("row%0d_ram_we", i), {28'd0, ram_we}, {28'd0, vt[i].we});
      chk($sformatf("row%0d_ram_addr", i), {16'd0, ram_addr}, {16'd0, vt[i].ra});
      chk($sformatf("row%0d_oor_err", i), {31'd0, oor_err}, {31'd0, vt[i].oor});
      chk($sformatf("row%0d_grant_id", i), {31'd0, grant_id}, {31'd0, vt[i].gid});
    end
    chk("oor_mem0_untouched", mem[0], 32'd0);

    // Contention: both valid in the same IDLE cycle; last grant was m0
    t0 = -1; t1 = -1; d0 = '0; d1 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(t0 < 0, 32'h10, 0, 0, t1 < 0, 32'h20, 0, 0);
      #1;
      if (m0_if.ready && t0 < 0) begin t0 = c; d0 = m0_if.rdata; end
      if (m1_if.ready && t1 < 0) begin t1 = c; d1 = m1_if.rdata; end
    end
`ifdef BRAM_ARB_RR_EN
    chk("tie_m0_cycle", t0, 32'd4);
    chk("tie_m1_cycle", t1, 32'd2);
`else
    chk("tie_m0_cycle", t0, 32'd2);
    chk("tie_m1_cycle", t1, 32'd4);
`endif
    chk("tie_m0_rdata", d0, 32'hDEAD_BEEF);
    chk("tie_m1_rdata", d1, 32'hAABB_33DD);

    // Streaming: both hold valid for 10 accesses each
    n0 = 0; n1 = 0; nr = 0; alt_err = 0; gap_err = 0; rd_err = 0; last_c = 0; last_id = 1'b0;
    for (int c = 0; c < 200 && (n0 < 10 || n1 < 10); c++) begin
      @(negedge clk);
      drive(n0 < 10, 32'h10, 0, 0, n1 < 10, 32'h20, 0, 0);
      #1;
      if (m0_if.ready || m1_if.ready) begin
        if (nr > 0) begin
          if (m1_if.ready == last_id) alt_err++;
          if (c - last_c != 2) gap_err++;
        end
        if (m0_if.ready && m0_if.rdata != 32'hDEAD_BEEF) rd_err++;
        if (m1_if.ready && m1_if.rdata != 32'hAABB_33DD) rd_err++;
        if (m0_if.ready) n0++;
        if (m1_if.ready) n1++;
        last_id = m1_if.ready;
        last_c = c;
        nr++;
      end
    end
    chk("stream_m0_count", n0, 32'd10);
    chk("stream_m1_count", n1, 32'd10);
    chk("stream_alternation_errs", alt_err, 32'd0);
    chk("stream_gap_errs", gap_err, 32'd0);
    chk("stream_rdata_errs", rd_err, 32'd0);

    // Reset while an m1 write sits in ACCESS
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h30, 32'h5555_5555, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstacc_ram_we", {28'd0, ram_we}, 32'd0);
    chk("rstacc_m1_ready", {31'd0, m1_if.ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstacc_next_m1_ready", {31'd0, m1_if.ready}, 32'd0);
    chk("rstacc_next_ram_we", {28'd0, ram_we}, 32'd0);
    t0 = -1; d0 = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(t0 < 0, 32'h30, 0, 0, 0, 0, 0, 0);
      #1;
      if (m1_if.ready) chk("rstacc_stray_m1_ready", 32'd1, 32'd0);
      if (m0_if.ready && t0 < 0) begin t0 = c; d0 = m0_if.rdata; end
    end
    chk("rstacc_readback_cycle", t0, 32'd2);
    chk("rstacc_readback_data", d0, 32'h0BAD_F00D);
    chk("rstacc_mem12_untouched", mem[12], 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
